// File: rtl/alu_seq_pkg.sv
// Shared types and seven-segment glyph constants for the alu_seq calculator.
// Optional multiplier datapath is selected in alu_seq by the ALU_MUL_EN macro.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ACC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Segment order: bit0..bit6 = a..g, bit7 = dot
    localparam logic [7:0] SEG_GLYPH_0 = 8'h3F;
    localparam logic [7:0] SEG_GLYPH_1 = 8'h06;
    localparam logic [7:0] SEG_GLYPH_2 = 8'h5B;
    localparam logic [7:0] SEG_GLYPH_3 = 8'h4F;
    localparam logic [7:0] SEG_GLYPH_4 = 8'h66;
    localparam logic [7:0] SEG_GLYPH_5 = 8'h6D;
    localparam logic [7:0] SEG_GLYPH_6 = 8'h7D;
    localparam logic [7:0] SEG_GLYPH_7 = 8'h07;
    localparam logic [7:0] SEG_GLYPH_8 = 8'h7F;
    localparam logic [7:0] SEG_GLYPH_9 = 8'h6F;
    localparam logic [7:0] SEG_GLYPH_A = 8'h77;
    localparam logic [7:0] SEG_GLYPH_B = 8'h7C;
    localparam logic [7:0] SEG_GLYPH_C = 8'h39;
    localparam logic [7:0] SEG_GLYPH_D = 8'h5E;
    localparam logic [7:0] SEG_GLYPH_E = 8'h79;
    localparam logic [7:0] SEG_GLYPH_F = 8'h71;
    localparam logic [7:0] SEG_DOT     = 8'h80;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder with dot control.
module hex_to_seg7
    import alu_seq_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_GLYPH_0;
        case (nibble)
            4'h0: glyph = SEG_GLYPH_0;
            4'h1: glyph = SEG_GLYPH_1;
            4'h2: glyph = SEG_GLYPH_2;
            4'h3: glyph = SEG_GLYPH_3;
            4'h4: glyph = SEG_GLYPH_4;
            4'h5: glyph = SEG_GLYPH_5;
            4'h6: glyph = SEG_GLYPH_6;
            4'h7: glyph = SEG_GLYPH_7;
            4'h8: glyph = SEG_GLYPH_8;
            4'h9: glyph = SEG_GLYPH_9;
            4'hA: glyph = SEG_GLYPH_A;
            4'hB: glyph = SEG_GLYPH_B;
            4'hC: glyph = SEG_GLYPH_C;
            4'hD: glyph = SEG_GLYPH_D;
            4'hE: glyph = SEG_GLYPH_E;
            default: glyph = SEG_GLYPH_F;
        endcase
    end

    assign seg = glyph | (dot ? SEG_DOT : 8'h00);

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential calculator: add/sub/accumulate in one cycle, shift-add multiply
// over NBITS cycles when ALU_MUL_EN is defined (otherwise MUL reports ovf with result 0).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NBITS = 3
) (
    input  logic               clk_2,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    input  logic               acc_clr,
    output logic               busy,
    output logic               done,
    output logic [2*NBITS-1:0] result,
    output logic               ovf,
    output logic               neg,
    output logic [7:0]         SEG
);

    localparam int RW = 2 * NBITS;

    state_t        state, state_n;
    op_t           op_e;
    logic [RW-1:0] acc;
    logic [RW-1:0] a_ext, b_ext, add_w, sub_w, acc_base;
    logic [RW:0]   acc_w;
    logic          fin;
    logic [RW-1:0] fin_result;
    logic          fin_ovf, fin_neg;
    logic [7:0]    seg_w;

    assign op_e     = op_t'(op);
    assign a_ext    = {{NBITS{1'b0}}, a};
    assign b_ext    = {{NBITS{1'b0}}, b};
    assign add_w    = a_ext + b_ext;
    assign sub_w    = a_ext - b_ext;
    // A same-cycle clear takes effect before the accumulate
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_w    = {1'b0, acc_base} + {1'b0, a_ext};

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(NBITS);

    logic [RW-1:0]    mcand, prod, prod_next;
    logic [NBITS-1:0] mplier;
    logic [CW-1:0]    cnt;

    assign prod_next = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk_2) begin
        if (state == IDLE && start && op_e == OP_MUL) begin
            mcand  <= a_ext;
            mplier <= b;
            prod   <= '0;
            cnt    <= CW'(NBITS - 1);
        end else if (state == CALC) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_next;
            cnt    <= cnt - CW'(1);
        end
    end
`endif

    always_comb begin
        state_n    = state;
        fin        = 1'b0;
        fin_result = '0;
        fin_ovf    = 1'b0;
        fin_neg    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    case (op_e)
                        OP_ADD: begin
                            fin_result = add_w;
                            fin_ovf    = add_w[NBITS];
                        end
                        OP_SUB: begin
                            fin_result = sub_w;
                            fin_neg    = (a < b);
                        end
                        OP_ACC: begin
                            fin_result = acc_w[RW-1:0];
                            fin_ovf    = acc_w[RW];
                        end
                        default: begin
`ifdef ALU_MUL_EN
                            state_n = CALC;
                            fin     = 1'b0;
`else
                            fin_ovf = 1'b1;
`endif
                        end
                    endcase
                end
            end
`ifdef ALU_MUL_EN
            CALC: begin
                if (cnt == '0) begin
                    state_n    = DONE;
                    fin        = 1'b1;
                    fin_result = prod_next;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (fin_result[3:0]),
        .dot    (fin_ovf),
        .seg    (seg_w)
    );

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
            SEG    <= SEG_GLYPH_0;
        end else begin
            if (fin) begin
                result <= fin_result;
                ovf    <= fin_ovf;
                neg    <= fin_neg;
                SEG    <= seg_w;
            end
            if (state == IDLE) begin
                if (start && op_e == OP_ACC) acc <= acc_w[RW-1:0];
                else if (acc_clr)            acc <= '0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential calculator block: latches two NBITS operands on a start pulse and computes add, subtract, accumulate, or shift-add multiply. It holds the result and status flags in registers and drives one seven-segment digit showing the low result nibble in hex. It sits behind the switch/LED/SEG front panel in `top`, replacing the purely combinational 3-bit add/sub path with a handshaked, multi-cycle unit.

## Interface
- `NBITS`, default 3: operand width; must be ≥ 2.
- `clk_2` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: operation select.
  - 00 ADD.
  - 01 SUB.
  - 10 MUL.
  - 11 ACC, meaning acc + a.
- `a`, `b` in NBITS: operands; unsigned.
- `acc_clr` in 1: clears the accumulator; honoured only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; result is valid.
- `result` out 2*NBITS: registered result.
- `ovf` out 1: overflow/error flag.
- `neg` out 1: SUB result was negative.
- `SEG` out 8: seven-segment pattern.
  - bit0..bit6 map to segments a..g.
  - bit7 is the dot.

## Operation
**FSM states:** IDLE, CALC, DONE.
- IDLE with `start`=1:
  - Latch `a`, `b` and `op`.
  - MUL goes to CALC.
  - Every other op goes to DONE and writes result and flags on the same edge.
- CALC:
  - Shift-add multiply, one multiplier bit per cycle, LSB first.
  - Runs exactly NBITS cycles, then goes to DONE with the product registered.
- DONE: lasts one cycle; `done`=1; then returns to IDLE.
- `start` in CALC or DONE is ignored; no queuing.

**Arithmetic (2*NBITS result, operands zero-extended):**
- ADD: result = a+b; ovf = bit NBITS of the sum, i.e. the sum exceeds the operand range; neg = 0.
- SUB: result = a−b in two's complement, sign-extended to 2*NBITS; neg = (a<b); ovf = 0.
- MUL: result = a*b, which always fits; ovf = 0; neg = 0.
- ACC: acc ← acc + a, modulo 2^(2*NBITS); result = new acc; ovf = carry out of 2*NBITS; neg = 0.

**Accumulator:**
- The accumulator is a 2*NBITS register, independent of `result`.
- `acc_clr` in IDLE zeroes it.
- If `acc_clr` and `start` with ACC occur in the same cycle, the clear applies first, so result = a.

**Hold and display:**
- result, ovf and neg hold until the next completed operation.
- SEG is registered on the same edge as result.
  - Low 7 bits: hex glyph of result[3:0].
  - Bit 7: new ovf.

**Glyph encoding:**
- Digits 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Letters A–F: 77 7C 39 5E 79 71.

## Timing
**Reset:** `rst_n`=0 at an edge forces the following register values:
- state = IDLE, acc = 0.
- busy = 0, done = 0.
- result = 0, ovf = 0, neg = 0.
- SEG = 0x3F.

**Reset mid-CALC:** abort the operation; no `done` pulse.

**Latency:**
- ADD, SUB, ACC: start sampled at edge 0; `done` high during cycle 1.
- MUL: `busy` high in cycles 1..NBITS+1; `done` high during cycle NBITS+1.

**Outputs during a MUL:** result and SEG show the previous value until the DONE edge. No intermediate values are visible.

**Back-to-back operations:** the earliest next start is the cycle after DONE, when IDLE has been re-entered.

## Configuration
- `ALU_MUL_EN` defined:
  - The CALC state and shift-add datapath are compiled in.
  - MUL behaves as above.
- `ALU_MUL_EN` undefined:
  - No CALC state and no multiplier registers.
  - op 10 completes like ADD in 1 cycle with result = 0 and ovf = 1, as an error indication.
  - All other ops are unchanged.

## Structure
- Package `alu_seq_pkg` holds:
  - `op_t` enum: ADD, SUB, MUL, ACC.
  - `state_t` enum: IDLE, CALC, DONE.
  - The sixteen SEG glyph constants and the dot constant.
- Sub-module `hex_to_seg7`: combinational 4-bit → 8-bit glyph decoder with a dot input. It is instantiated once, and its output is registered in `alu_seq`.

## Test plan
All scenarios use NBITS=3.
1. Hold `rst_n`=0 for 2 cycles, then release → busy=0, done=0, result=0, ovf=0, neg=0, SEG=0x3F.
2. ADD a=5, b=6 → `done` in cycle 1; result=0x0B, ovf=1, SEG=0xFC.
3. SUB a=2, b=5 → result=0x3D, neg=1, ovf=0, SEG=0x5E.
4. MUL a=7, b=7 → busy for cycles 1–4, done in cycle 4; result=0x31, SEG=0x06.
   - A `start` pulse during busy is ignored.
   - Without `ALU_MUL_EN`: result=0, ovf=1, done in cycle 1.
5. ACC sequence, starting from `acc_clr` together with ACC a=7:
   - First result is 7.
   - Nine ACCs of a=7 in total give 63 with ovf=0.
   - The tenth gives result=6, ovf=1.
6. Start MUL a=7, b=7, then assert `rst_n`=0 at cycle 2 → IDLE next cycle, no done pulse, result=0, acc=0.
